// File: rtl/debounce_bank_pkg.sv
// -----------------------------------------------------------------------------
// debounce_bank_pkg
// Shared definitions for the multi-channel button debouncer:
//   - default parameter values for the bank
//   - cnt_width(): bits needed to hold the values 0..n
//   - params_legal(): parameter sanity check used at elaboration
//   - ch_status_t: per-channel result bundle (level plus event pulses)
// No ports; imported by the interface, the channel and the top.
// -----------------------------------------------------------------------------
package debounce_bank_pkg;

  localparam int DEF_NUM_CH       = 3;
  localparam int DEF_TICK_DIV     = 1;
  localparam int DEF_STABLE_TICKS = 8;
  localparam int DEF_HOLD_TICKS   = 0;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic held;
  } ch_status_t;

  // Counter width for a range of 0..n. Never returns 0, so a degenerate
  // range still yields a declarable vector.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic bit params_legal(input int num_ch, input int tick_div,
                                      input int stable_ticks, input int hold_ticks);
    return (num_ch >= 1) && (tick_div >= 1) && (stable_ticks >= 1) && (hold_ticks >= 0);
  endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// -----------------------------------------------------------------------------
// debounce_bank_if
// Bundles the raw pad inputs and the filtered per-channel outputs.
//   button     raw asynchronous button levels, bit i = channel i
//   debounced  filtered level per channel
//   rise       one-cycle pulse on debounced 0->1
//   fall       one-cycle pulse on debounced 1->0
//   held       one-cycle pulse when a press has lasted HOLD_TICKS ticks
// master: the pad / user side (drives button). slave: the debouncer.
// -----------------------------------------------------------------------------
interface debounce_bank_if
  import debounce_bank_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH
);

  logic [NUM_CH-1:0] button;
  logic [NUM_CH-1:0] debounced;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic [NUM_CH-1:0] held;

  modport master (output button, input debounced, rise, fall, held);
  modport slave  (input button, output debounced, rise, fall, held);

endinterface

// File: rtl/debounce_bank_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One debounce lane: 2-flop synchroniser, stability filter, edge pulses and
// optional long-press detection.
//   clk     system clock
//   reset   asynchronous active-high reset, clears every flop
//   tick    shared sample strobe from the bank prescaler
//   button  raw asynchronous input for this lane
//   status  level / rise / fall / held for this lane (all registered)
// -----------------------------------------------------------------------------
module debounce_channel
  import debounce_bank_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       button,
  output ch_status_t status
);

  localparam int             CW   = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0]  LAST = CW'(STABLE_TICKS - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] stab_cnt;
  logic          level;
  logic          rise;
  logic          fall;
  logic          held;

  // Stage p0/p1: metastability synchroniser
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= button;
      sync_p1 <= sync_p0;
    end
  end

  // Stability filter: any cycle where the synchronised input agrees with the
  // current level restarts the count, even between ticks, so a glitch of any
  // length short of STABLE_TICKS ticks is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stab_cnt <= '0;
      level    <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync_p1 == level) begin
        stab_cnt <= '0;
      end else if (tick) begin
        if (stab_cnt == LAST) begin
          level    <= sync_p1;
          stab_cnt <= '0;
          rise     <= sync_p1;
          fall     <= ~sync_p1;
        end else begin
          stab_cnt <= stab_cnt + 1'b1;
        end
      end
    end
  end

  // Long-press detection: counts ticks of a stable high level and saturates,
  // so held fires once per press.
  if (HOLD_TICKS > 0) begin : g_hold
    localparam int            HW       = cnt_width(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

    logic [HW-1:0] hold_cnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hold_cnt <= '0;
        held     <= 1'b0;
      end else begin
        held <= 1'b0;
        if (!level) begin
          hold_cnt <= '0;
        end else if (tick && (hold_cnt != HOLD_MAX)) begin
          hold_cnt <= hold_cnt + 1'b1;
          held     <= (hold_cnt == HOLD_MAX - 1'b1);
        end
      end
    end
  end else begin : g_no_hold
    assign held = 1'b0;
  end

  assign status = '{level: level, rise: rise, fall: fall, held: held};

endmodule

// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
// Multi-channel push-button debouncer. Owns the shared sample prescaler and
// one debounce_channel per button.
//   clk    system clock, all state on the rising edge
//   reset  asynchronous active-high reset, clears all state and outputs
//   bus    debounce_bank_if.slave: button in; debounced/rise/fall/held out
// Parameters: NUM_CH channels, TICK_DIV clocks per sample tick, STABLE_TICKS
// ticks of a changed input to flip a level, HOLD_TICKS ticks of high level
// before held fires (0 disables held).
// -----------------------------------------------------------------------------
module debounce_bank
  import debounce_bank_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS
) (
  input logic            clk,
  input logic            reset,
  debounce_bank_if.slave bus
);

  if (!params_legal(NUM_CH, TICK_DIV, STABLE_TICKS, HOLD_TICKS)) begin : g_bad_params
    $fatal(1, "debounce_bank: NUM_CH, TICK_DIV and STABLE_TICKS must be >= 1, HOLD_TICKS >= 0");
  end

  logic tick;

  // Shared prescaler: tick on the last count of each TICK_DIV-cycle period
  if (TICK_DIV == 1) begin : g_no_presc
    assign tick = 1'b1;
  end else begin : g_presc
    localparam int            PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_cnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        presc_cnt <= '0;
      end else begin
        presc_cnt <= (presc_cnt == PMAX) ? '0 : presc_cnt + 1'b1;
      end
    end

    assign tick = (presc_cnt == PMAX);
  end

  ch_status_t status [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .HOLD_TICKS   (HOLD_TICKS)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .button (bus.button[i]),
      .status (status[i])
    );

    assign bus.debounced[i] = status[i].level;
    assign bus.rise[i]      = status[i].rise;
    assign bus.fall[i]      = status[i].fall;
    assign bus.held[i]      = status[i].held;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// -----------------------------------------------------------------------------
// tb_debounce_bank
// Three debounce_bank instances with different configurations share one clock,
// one reset and one button stream:
//   dut0: TICK_DIV=1, STABLE_TICKS=8, HOLD_TICKS=0  (defaults)
//   dut1: TICK_DIV=4, STABLE_TICKS=3, HOLD_TICKS=5
//   dut2: TICK_DIV=1, STABLE_TICKS=8, HOLD_TICKS=20
// A behavioural model derives every output from edge counts: a level flips on
// the tick edge where an unbroken run of disagreeing synchronised samples has
// spanned STABLE_TICKS ticks; held fires on the tick edge that is exactly
// HOLD_TICKS ticks after the rise edge while the level is still high.
// -----------------------------------------------------------------------------
module tb_debounce_bank;

  localparam int NC = 3;
  localparam int NI = 3;
  localparam int CFG_D [NI] = '{1, 4, 1};
  localparam int CFG_S [NI] = '{8, 3, 8};
  localparam int CFG_H [NI] = '{0, 5, 20};

  logic          clk    = 1'b0;
  logic          reset  = 1'b0;
  logic [NC-1:0] button = '0;
  bit            cmp_en = 1'b0;
  int            n_checks = 0;
  int            n_fail   = 0;

  always #5 clk = ~clk;

  debounce_bank_if #(.NUM_CH(NC)) bus0 ();
  debounce_bank_if #(.NUM_CH(NC)) bus1 ();
  debounce_bank_if #(.NUM_CH(NC)) bus2 ();

  assign bus0.button = button;
  assign bus1.button = button;
  assign bus2.button = button;

  debounce_bank #(.NUM_CH(NC), .TICK_DIV(CFG_D[0]), .STABLE_TICKS(CFG_S[0]), .HOLD_TICKS(CFG_H[0]))
    dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  debounce_bank #(.NUM_CH(NC), .TICK_DIV(CFG_D[1]), .STABLE_TICKS(CFG_S[1]), .HOLD_TICKS(CFG_H[1]))
    dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  debounce_bank #(.NUM_CH(NC), .TICK_DIV(CFG_D[2]), .STABLE_TICKS(CFG_S[2]), .HOLD_TICKS(CFG_H[2]))
    dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  logic [NC-1:0] deb_a  [NI];
  logic [NC-1:0] rise_a [NI];
  logic [NC-1:0] fall_a [NI];
  logic [NC-1:0] held_a [NI];

  assign deb_a[0] = bus0.debounced;  assign rise_a[0] = bus0.rise;
  assign fall_a[0] = bus0.fall;      assign held_a[0] = bus0.held;
  assign deb_a[1] = bus1.debounced;  assign rise_a[1] = bus1.rise;
  assign fall_a[1] = bus1.fall;      assign held_a[1] = bus1.held;
  assign deb_a[2] = bus2.debounced;  assign rise_a[2] = bus2.rise;
  assign fall_a[2] = bus2.fall;      assign held_a[2] = bus2.held;

  // ---------------- behavioural model ----------------
  int            e = 0;              // rising edges since reset release
  logic [NC-1:0] bq1 = '0;           // button seen at edge e-1
  logic [NC-1:0] bq2 = '0;           // button seen at edge e-2
  logic [NC-1:0] x_deb  [NI] = '{default: '0};
  logic [NC-1:0] x_rise [NI] = '{default: '0};
  logic [NC-1:0] x_fall [NI] = '{default: '0};
  logic [NC-1:0] x_held [NI] = '{default: '0};
  int            run_start [NI][NC];
  int            rise_edge [NI][NC];

  task automatic model_clear();
    e = 0;
    bq1 = '0;
    bq2 = '0;
    for (int k = 0; k < NI; k++) begin
      x_deb[k] = '0; x_rise[k] = '0; x_fall[k] = '0; x_held[k] = '0;
      for (int i = 0; i < NC; i++) begin
        run_start[k][i] = -1;
        rise_edge[k][i] = 0;
      end
    end
  endtask

  task automatic model_step();
    bit   tick;
    logic s, old;
    e = e + 1;
    for (int k = 0; k < NI; k++) begin
      tick = ((e % CFG_D[k]) == 0);
      x_rise[k] = '0; x_fall[k] = '0; x_held[k] = '0;
      for (int i = 0; i < NC; i++) begin
        s   = bq2[i];
        old = x_deb[k][i];
        if (CFG_H[k] > 0 && old && tick &&
            (e / CFG_D[k] - rise_edge[k][i] / CFG_D[k]) == CFG_H[k])
          x_held[k][i] = 1'b1;
        if (s == old) begin
          run_start[k][i] = -1;
        end else begin
          if (run_start[k][i] < 0) run_start[k][i] = e;
          // ticks contained in edges run_start..e
          if (tick && (e / CFG_D[k] - (run_start[k][i] - 1) / CFG_D[k]) == CFG_S[k]) begin
            x_deb[k][i]  = s;
            x_rise[k][i] = s;
            x_fall[k][i] = ~s;
            run_start[k][i] = -1;
            if (s) rise_edge[k][i] = e;
          end
        end
      end
    end
    bq2 = bq1;
    bq1 = button;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_clear();
    else       model_step();
  end

  // ---------------- checking ----------------
  task automatic check_vec(input string name, input int k, input logic [NC-1:0] act,
                           input logic [NC-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d edge %0d: got %b expected %b", name, k, e, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < NI; k++) begin
        check_vec("debounced", k, deb_a[k], x_deb[k]);
        check_vec("rise", k, rise_a[k], x_rise[k]);
        check_vec("fall", k, fall_a[k], x_fall[k]);
        check_vec("held", k, held_a[k], x_held[k]);
      end
    end
  end

  // sel: 0 = rise, 1 = fall, 2 = held. Returns the edge index or -1.
  task automatic wait_pulse(input int sel, input int k, input int ch, input int bound,
                            output int at);
    at = -1;
    for (int t = 0; t < bound && at < 0; t++) begin
      @(negedge clk);
      case (sel)
        0:       if (rise_a[k][ch]) at = e;
        1:       if (fall_a[k][ch]) at = e;
        default: if (held_a[k][ch]) at = e;
      endcase
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int r0, r1, r2, h2, f0, base, cnt, hits, rate;
    int rates [8];
    rates = '{2, 5, 9, 15, 30, 60, 120, 250};

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    button = 3'b001;
    cmp_en = 1'b1;

    // clean press on channel 0, all three configurations
    r0 = -1; r1 = -1; r2 = -1; h2 = -1; cnt = 0; hits = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (rise_a[0][0]) begin cnt++; if (r0 < 0) r0 = e; end
      if (rise_a[1][0] && r1 < 0) r1 = e;
      if (rise_a[2][0] && r2 < 0) r2 = e;
      if (held_a[2][0]) begin hits++; if (h2 < 0) h2 = e; end
    end
    check_int("press_latency", r0, 10);
    check_int("rise_width", cnt, 1);
    check_int("presc_latency_in_range", int'(r1 >= 11 && r1 <= 14), 1);
    check_int("presc_latency", r1, 12);
    check_int("held_delay", h2 - r2, 20);

    // keep holding: no second held pulse
    repeat (100) begin
      @(negedge clk);
      if (held_a[2][0]) hits++;
    end
    check_int("held_once", hits, 1);

    // release
    button[0] = 1'b0;
    base = e;
    wait_pulse(1, 0, 0, 30, f0);
    check_int("fall_latency", f0 - base, 10);
    repeat (30) @(negedge clk);

    // re-press re-arms the hold detector
    button[0] = 1'b1;
    wait_pulse(0, 2, 0, 30, r2);
    wait_pulse(2, 2, 0, 40, h2);
    check_int("held_rearm", h2 - r2, 20);

    // bounce on channel 1: toggle every 3 cycles for 60 cycles
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      button[1] = ((i % 2) == 0);
      repeat (3) begin
        @(negedge clk);
        if (rise_a[0][1] | rise_a[1][1] | rise_a[2][1]) cnt++;
      end
    end
    check_int("bounce_no_rise", cnt, 0);
    button[1] = 1'b1;
    base = e;
    wait_pulse(0, 0, 1, 30, r0);
    check_int("bounce_settle_latency", r0 - base, 10);
    repeat (30) @(negedge clk);

    // 5-cycle glitch on channel 2 must not propagate
    button[2] = 1'b1;
    repeat (5) @(negedge clk);
    button[2] = 1'b0;
    hits = 0;
    repeat (30) begin
      @(negedge clk);
      if (deb_a[0][2] | deb_a[1][2] | deb_a[2][2]) hits++;
    end
    check_int("glitch_blocked", hits, 0);

    // all channels step together
    button = '0;
    repeat (30) @(negedge clk);
    button = '1;
    base = e;
    r0 = -1; r1 = -1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (rise_a[0] != '0 && r0 < 0) begin r0 = e; check_vec("parallel_rise", 0, rise_a[0], 3'b111); end
      if (rise_a[1] != '0 && r1 < 0) begin r1 = e; check_vec("parallel_rise", 1, rise_a[1], 3'b111); end
    end
    check_int("parallel_latency", r0 - base, 10);
    check_int("parallel_presc_seen", int'(r1 > 0), 1);

    // asynchronous reset in the middle of a release count
    button = '0;
    repeat (5) @(negedge clk);
    check_vec("pre_reset_level", 0, deb_a[0], 3'b111);
    @(posedge clk);
    #2;
    button = '1;
    reset  = 1'b1;
    #1;
    for (int k = 0; k < NI; k++)
      check_vec("async_reset_clears", k, deb_a[k] | rise_a[k] | fall_a[k] | held_a[k], '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_pulse(0, 0, 0, 30, r0);
    check_int("post_reset_latency", r0, 10);
    repeat (20) @(negedge clk);

    // randomized toggling at several rates, with one reset mid-run
    for (int seg = 0; seg < 8; seg++) begin
      rate = rates[seg];
      for (int t = 0; t < 300; t++) begin
        if (seg == 4 && t == 150) begin
          @(posedge clk);
          #3 reset = 1'b1;
          @(negedge clk);
          @(negedge clk);
          reset = 1'b0;
        end
        @(negedge clk);
        for (int i = 0; i < NC; i++)
          if ($urandom_range(rate - 1) == 0) button[i] = ~button[i];
      end
    end
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel button debouncer with a shared sample-rate prescaler, edge pulses, and optional long-press detection. It sits between the raw pad inputs and the user-control logic, replacing per-button single-channel debouncers with one block that covers all push-buttons. Each channel is synchronised, then filtered by a stability counter. Each channel reports a level, one-cycle press/release pulses, and a one-shot hold pulse.

## Interface
- NUM_CH, 3: number of independent button channels (≥1)
- TICK_DIV, 1: prescaler. One sample tick every TICK_DIV clk cycles (≥1; 1 = every cycle)
- STABLE_TICKS, 8: consecutive ticks of a changed input required to flip the debounced level (≥1)
- HOLD_TICKS, 0: ticks of continuous debounced-high before `held` fires. 0 disables hold detection.
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- button  in  NUM_CH  raw, asynchronous button inputs; bit i = channel i
- debounced  out  NUM_CH  filtered level per channel
- rise  out  NUM_CH  one-cycle pulse when debounced[i] goes 0→1
- fall  out  NUM_CH  one-cycle pulse when debounced[i] goes 1→0
- held  out  NUM_CH  one-cycle pulse when channel i has been debounced-high for HOLD_TICKS ticks

## Operation
- Reset (async, any time): all synchroniser flops, counters, the prescaler, and all outputs are cleared to 0. Any filtering in progress is discarded.
- Synchroniser: 2 flops per channel. `sync[i]` is button[i] delayed by 2 clk.
- Prescaler: free-running counter 0..TICK_DIV-1. `tick` is high when it equals TICK_DIV-1; it wraps to 0. With TICK_DIV=1, tick is constantly 1. The prescaler is shared by all channels.
- Stability counter per channel, width $clog2(STABLE_TICKS+1):
  - sync[i]==debounced[i]: counter ← 0 on every clk, including non-tick cycles. A single-cycle glitch therefore restarts the count.
  - mismatch and tick, counter < STABLE_TICKS-1: counter increments.
  - mismatch and tick, counter == STABLE_TICKS-1: debounced[i] ← sync[i] and counter ← 0. On the same edge, rise[i] or fall[i] ← 1.
  - rise/fall are registered and high for exactly one clk, aligned with the debounced transition.
- Hold counter per channel (only when HOLD_TICKS>0):
  - Cleared while debounced[i]==0.
  - Increments on each tick while debounced[i]==1 and saturates at HOLD_TICKS.
  - held[i] pulses for one clk on the edge the counter reaches HOLD_TICKS. There is no repeat until the channel releases and presses again.
- If HOLD_TICKS=0, held is constant 0.
- Channels are fully independent; simultaneous events on several channels are handled in parallel.

## Timing
- TICK_DIV=1: a clean input step at edge N (captured by sync flop 1) flips debounced at edge N+1+STABLE_TICKS. That is STABLE_TICKS+2 cycles of input-to-output latency.
- TICK_DIV>1: latency is 2 + (STABLE_TICKS-1)·TICK_DIV + phase, where phase ∈ [1, TICK_DIV] depends on prescaler alignment.
- rise/fall: never asserted together on the same channel. Minimum spacing between pulses on one channel is STABLE_TICKS ticks.
- held: earliest at HOLD_TICKS ticks after rise, counting starts from the first tick after rise.
- Input bouncing faster than STABLE_TICKS ticks never changes debounced.

## Structure
- Shared package/header holds:
  - the default parameter values
  - a width helper for counter sizing ($clog2(n+1))
  - parameter legality checks (TICK_DIV≥1, STABLE_TICKS≥1, NUM_CH≥1), which stop elaboration on violation
- Sub-module `debounce_channel`: synchroniser, stability counter, hold counter, and edge pulses for one bit. It takes `tick` as an input.
- Top `debounce_bank` owns the prescaler and generates NUM_CH instances.

## Test plan
- Reset: assert reset asynchronously mid-cycle with button all 1 → all outputs 0 immediately. After release with button held high, debounced=1 at cycle 10 (NUM_CH=3, TICK_DIV=1, STABLE_TICKS=8).
- Clean press/release, defaults: button[0] high at cycle 0 → debounced[0]=1 and rise[0] high for exactly cycle 10. Release at cycle 40 → fall[0] pulse at cycle 50.
- Bounce rejection: button[1] toggles every 3 cycles for 60 cycles, then holds 1 → no rise during bouncing. One rise fires 10 cycles after the final edge.
- Prescaler: TICK_DIV=4, STABLE_TICKS=3 → press visible after 2+8+phase cycles, phase 1..4. A 5-cycle glitch never propagates.
- Long press: HOLD_TICKS=20, TICK_DIV=1 → held pulses once exactly 20 cycles after rise. Holding 100 more cycles gives no second pulse. Release and re-press re-arms it.
- Parallel channels: all three buttons step simultaneously → three rise pulses on the same cycle. A reset asserted during counting restarts every channel from 0.
